mem_stage: RTL

// Memory-access pipeline stage; consumes the EX->MEM bus fields (req, we, wdata_src, data_src, rwaddr, wdata, regs_*).

---
 rtl/mem_stage.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage.
// Holds one EX instruction and drives its data SRAM request/response handshake.
// Stores are lane-aligned when accepted; load data is shifted and extended on the response.
// The result goes to WB, and the stage contents are mirrored on the ID forwarding bus.
`timescale 1ns/1ps
module mem_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  output logic              mem_allowin_o,
  input  logic              ex_mem_req_i,
  input  logic              ex_mem_we_i,
  input  logic              ex_wdata_src_i,
  input  logic [2:0]        ex_data_src_i,
  input  logic [ADDR_W-1:0] ex_rwaddr_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              ex_regs_we_i,
  input  logic [4:0]        ex_regs_waddr_i,
  input  logic [DATA_W-1:0] ex_regs_wdata_i,
  input  logic              wb_allowin_i,
  output logic              mem_to_wb_valid_o,
  output logic              wb_regs_we_o,
  output logic [4:0]        wb_regs_waddr_o,
  output logic [DATA_W-1:0] wb_regs_wdata_o,
  output logic              fwd_regs_we_o,
  output logic [4:0]        fwd_regs_waddr_o,
  output logic [DATA_W-1:0] fwd_regs_wdata_o,
  output logic              fwd_load_pend_o,
  output logic              dsram_req_o,
  output logic              dsram_wr_o,
  output logic [1:0]        dsram_size_o,
  output logic [3:0]        dsram_wstrb_o,
  output logic [ADDR_W-1:0] dsram_addr_o,
  output logic [DATA_W-1:0] dsram_wdata_o,
  input  logic              dsram_addr_ok_i,
  input  logic              dsram_data_ok_i,
  input  logic [DATA_W-1:0] dsram_rdata_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Access size: 1/2 are byte, 3/4 are half, anything else is a word.
  function automatic logic [1:0] acc_size(input logic [2:0] src);
    case (src)
      3'd1, 3'd2: acc_size = 2'd0;
      3'd3, 3'd4: acc_size = 2'd1;
      default:    acc_size = 2'd2;
    endcase
  endfunction

  // Byte strobes; halfword ignores addr[0], word ignores addr[1:0].
  function automatic logic [3:0] store_strb(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'd0:    store_strb = 4'b0001 << a;
      2'd1:    store_strb = a[1] ? 4'b1100 : 4'b0011;
      default: store_strb = 4'b1111;
    endcase
  endfunction

  // Replicate the low byte/half across all lanes so any strobe picks the right data.
  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'd0:    store_data = {4{d[7:0]}};
      2'd1:    store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  // Select the addressed byte/half of the read word and sign/zero extend it.
  function automatic logic [31:0] load_ext(input logic [31:0] rd, input logic [1:0] a,
                                           input logic [2:0] src);
    logic [31:0] sh_b;
    logic [31:0] sh_h;
    sh_b = rd >> {a, 3'b000};
    sh_h = rd >> {a[1], 4'b0000};
    case (src)
      3'd1:    load_ext = {{24{sh_b[7]}}, sh_b[7:0]};
      3'd2:    load_ext = {24'd0, sh_b[7:0]};
      3'd3:    load_ext = {{16{sh_h[15]}}, sh_h[15:0]};
      3'd4:    load_ext = {16'd0, sh_h[15:0]};
      default: load_ext = rd;
    endcase
  endfunction

  logic [1:0]        state;
  logic              we_r;
  logic              wdata_src_r;
  logic [2:0]        data_src_r;
  logic [ADDR_W-1:0] rwaddr_r;
  logic [1:0]        size_r;
  logic [3:0]        wstrb_r;
  logic [DATA_W-1:0] sram_wdata_r;
  logic              regs_we_r;
  logic [4:0]        regs_waddr_r;
  logic [DATA_W-1:0] regs_wdata_r;
  logic [DATA_W-1:0] load_data_r;
  logic              accept;
  logic              capture;
  logic [DATA_W-1:0] result;

  // Handshake decode: when a new instruction enters and when a load response is taken.
  always_comb begin
    mem_allowin_o = (state == S_IDLE) || ((state == S_DONE) && wb_allowin_i);
    accept        = ex_valid_i && mem_allowin_o;
    capture       = ((state == S_REQ) && dsram_addr_ok_i && dsram_data_ok_i) ||
                    ((state == S_WAIT) && dsram_data_ok_i);
    result        = wdata_src_r ? load_data_r : regs_wdata_r;
  end

  // Stage FSM; data_ok outside REQ+addr_ok / WAIT is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) state <= ex_mem_req_i ? S_REQ : S_DONE;
          else        state <= S_IDLE;
        end
        S_REQ: begin
          if (dsram_addr_ok_i) state <= dsram_data_ok_i ? S_DONE : S_WAIT;
          else                 state <= S_REQ;
        end
        S_WAIT: begin
          if (dsram_data_ok_i) state <= S_DONE;
          else                 state <= S_WAIT;
        end
        S_DONE: begin
          if (accept)            state <= ex_mem_req_i ? S_REQ : S_DONE;
          else if (wb_allowin_i) state <= S_IDLE;
          else                   state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Latch EX fields (with pre-aligned store lanes) on accept; capture load data on response.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_r         <= 1'b0;
      wdata_src_r  <= 1'b0;
      data_src_r   <= 3'd0;
      rwaddr_r     <= '0;
      size_r       <= 2'd0;
      wstrb_r      <= 4'd0;
      sram_wdata_r <= '0;
      regs_we_r    <= 1'b0;
      regs_waddr_r <= 5'd0;
      regs_wdata_r <= '0;
      load_data_r  <= '0;
    end else if (accept) begin
      we_r         <= ex_mem_we_i;
      wdata_src_r  <= ex_wdata_src_i;
      data_src_r   <= ex_data_src_i;
      rwaddr_r     <= ex_rwaddr_i;
      size_r       <= acc_size(ex_data_src_i);
      wstrb_r      <= store_strb(acc_size(ex_data_src_i), ex_rwaddr_i[1:0]);
      sram_wdata_r <= store_data(acc_size(ex_data_src_i), ex_wdata_i);
      regs_we_r    <= ex_regs_we_i;
      regs_waddr_r <= ex_regs_waddr_i;
      regs_wdata_r <= ex_regs_wdata_i;
      load_data_r  <= '0;
    end else if (capture) begin
      load_data_r  <= load_ext(dsram_rdata_i, rwaddr_r[1:0], data_src_r);
    end else begin
      load_data_r  <= load_data_r;
    end
  end

  // Output drive from the stage registers.
  always_comb begin
    mem_to_wb_valid_o = (state == S_DONE);
    wb_regs_we_o      = regs_we_r;
    wb_regs_waddr_o   = regs_waddr_r;
    wb_regs_wdata_o   = result;
    fwd_regs_we_o     = (state != S_IDLE) && regs_we_r;
    fwd_regs_waddr_o  = regs_waddr_r;
    fwd_regs_wdata_o  = result;
    fwd_load_pend_o   = ((state == S_REQ) || (state == S_WAIT)) && !we_r && wdata_src_r;
    dsram_req_o       = (state == S_REQ);
    dsram_wr_o        = (state == S_REQ) && we_r;
    dsram_size_o      = size_r;
    dsram_wstrb_o     = ((state == S_REQ) && we_r) ? wstrb_r : 4'd0;
    dsram_addr_o      = rwaddr_r;
    dsram_wdata_o     = sram_wdata_r;
  end

endmodule
